// File: rtl/float8_accumulator_if.sv
// float8_accumulator_if
//   Groups the input term stream (valid/ready/data/last) and the output
//   sum stream (valid/ready/data/sat/count) of the float8 accumulator.
//   master : upstream/downstream side (drives terms, accepts sums)
//   slave  : accumulator side
//   CNT_W  : width of the per-packet term counter
interface float8_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_sat;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/float8_accumulator.sv
// float8_accumulator
//   Sums each packet of float8 terms (sign, 4-bit exponent bias 7, 3-bit
//   mantissa, e=0 means zero) into one float8 result using an
//   IDLE/ALIGN/ADD/NORM/OUT sequence.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : float8_accumulator_if.slave - term input stream and sum output
//         stream (out_data, out_sat, out_count held while out_valid)
module float8_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  float8_accumulator_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t             state_r;
  logic [7:0]         acc_r;
  logic               sat_r;
  logic [CNT_W-1:0]   count_r;
  logic [7:0]         term_r;
  logic               last_r;
  logic [6:0]         sig_a_r;
  logic [6:0]         sig_b_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic signed [5:0]  exp_r;   // wide enough for overflow (16) and underflow (<1)
  logic [7:0]         sum_r;
  logic               sign_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [7:0]         out_data_r;
  logic               out_sat_r;
  logic [CNT_W-1:0]   out_count_r;

  // Combinational datapath results consumed by the FSM.
  logic [3:0]         ea_s, eb_s, d_s, al_exp_s;
  logic [6:0]         full_a_s, full_b_s, al_a_s, al_b_s;
  logic [7:0]         add_sum_s;
  logic               add_sign_s;
  logic [7:0]         norm_val_s;
  logic signed [5:0]  norm_exp_s;
  logic               norm_done_s;
  logic               norm_sat_s;
  logic [7:0]         norm_res_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_count = out_count_r;

  // Alignment: the zero-exponent operand contributes a zero significand, so the
  // larger-exponent rule also picks the nonzero operand's exponent.
  always_comb begin
    ea_s     = acc_r[6:3];
    eb_s     = term_r[6:3];
    full_a_s = (ea_s == 4'd0) ? 7'd0 : {1'b1, acc_r[2:0], 3'b000};
    full_b_s = (eb_s == 4'd0) ? 7'd0 : {1'b1, term_r[2:0], 3'b000};
    if (ea_s >= eb_s) begin
      d_s      = ea_s - eb_s;
      al_exp_s = ea_s;
      al_a_s   = full_a_s;
      al_b_s   = (d_s >= 4'd7) ? 7'd0 : (full_b_s >> d_s);
    end else begin
      d_s      = eb_s - ea_s;
      al_exp_s = eb_s;
      al_a_s   = (d_s >= 4'd7) ? 7'd0 : (full_a_s >> d_s);
      al_b_s   = full_b_s;
    end
  end

  // Signed-magnitude add; an exact zero always comes out positive.
  always_comb begin
    if (sign_a_r == sign_b_r) begin
      add_sum_s  = {1'b0, sig_a_r} + {1'b0, sig_b_r};
      add_sign_s = sign_a_r;
    end else if (sig_a_r >= sig_b_r) begin
      add_sum_s  = {1'b0, sig_a_r} - {1'b0, sig_b_r};
      add_sign_s = sign_a_r;
    end else begin
      add_sum_s  = {1'b0, sig_b_r} - {1'b0, sig_a_r};
      add_sign_s = sign_b_r;
    end
    if (add_sum_s == 8'd0) begin
      add_sign_s = 1'b0;
    end else begin
      add_sign_s = add_sign_s;
    end
  end

  // Normalisation step: carry fixes in one cycle, each left shift costs a cycle.
  always_comb begin
    norm_val_s  = sum_r;
    norm_exp_s  = exp_r;
    norm_done_s = 1'b1;
    norm_sat_s  = 1'b0;
    norm_res_s  = 8'h00;
    if (sum_r == 8'd0) begin
      norm_done_s = 1'b1;
    end else if (sum_r[7]) begin
      norm_val_s = sum_r >> 1;
      norm_exp_s = exp_r + 6'sd1;
    end else if (sum_r[6]) begin
      norm_done_s = 1'b1;
    end else begin
      norm_val_s  = sum_r << 1;
      norm_exp_s  = exp_r - 6'sd1;
      norm_done_s = 1'b0;
    end
    if (sum_r == 8'd0) begin
      norm_res_s = 8'h00;
    end else if (norm_exp_s > 6'sd15) begin
      norm_res_s = {sign_r, 4'hF, 3'h7};
      norm_sat_s = 1'b1;
    end else if (norm_exp_s < 6'sd1) begin
      norm_res_s = 8'h00;   // underflow flushes to zero without flagging
    end else begin
      norm_res_s = {sign_r, norm_exp_s[3:0], norm_val_s[5:3]};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 8'h00;
      sat_r       <= 1'b0;
      count_r     <= '0;
      term_r      <= 8'h00;
      last_r      <= 1'b0;
      sig_a_r     <= 7'd0;
      sig_b_r     <= 7'd0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      exp_r       <= 6'sd0;
      sum_r       <= 8'd0;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_sat_r   <= 1'b0;
      out_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            term_r     <= bus.in_data;
            last_r     <= bus.in_last;
            if (count_r != {CNT_W{1'b1}}) begin
              count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            in_ready_r <= 1'b0;
            state_r    <= ALIGN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ALIGN: begin
          sig_a_r  <= al_a_s;
          sig_b_r  <= al_b_s;
          sign_a_r <= acc_r[7];
          sign_b_r <= term_r[7];
          exp_r    <= signed'({2'b00, al_exp_s});
          state_r  <= ADD;
        end
        ADD: begin
          sum_r   <= add_sum_s;
          sign_r  <= add_sign_s;
          state_r <= NORM;
        end
        NORM: begin
          if (norm_done_s) begin
            acc_r <= norm_res_s;
            if (norm_sat_s) begin
              sat_r <= 1'b1;
            end
            if (last_r) begin
              state_r <= OUT;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= IDLE;
            end
          end else begin
            sum_r <= norm_val_s;
            exp_r <= norm_exp_s;
          end
        end
        OUT: begin
          // First OUT cycle publishes the result; afterwards wait for the consumer.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_r;
            out_sat_r   <= sat_r;
            out_count_r <= count_r;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_sat_r   <= 1'b0;
            out_count_r <= '0;
            acc_r       <= 8'h00;
            sat_r       <= 1'b0;
            count_r     <= '0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float8_accumulator.sv
// tb_float8_accumulator
//   Directed test of float8_accumulator: packet sums, carry and cancellation
//   normalisation, truncation, zero handling, saturation with output hold,
//   and reset in the middle of a packet.
module tb_float8_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  float8_accumulator_if #(.CNT_W(8)) bus ();

  float8_accumulator #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure accept-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one term at a negedge and hold it until accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_bound", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
  endtask

  // Wait for a packet result and compare it, including latency.
  task automatic get(input string name, input logic [7:0] d, input logic s,
                     input logic [7:0] c, input int lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_bound"}, 32'(n < 60), 32'd1);
    chk({name, "_lat"},   32'(cyc - acc_cyc), 32'(lat));
    chk({name, "_data"},  32'(bus.out_data), 32'(d));
    chk({name, "_sat"},   32'(bus.out_sat), 32'(s));
    chk({name, "_count"}, 32'(bus.out_count), 32'(c));
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_sat",   32'(bus.out_sat),   32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;

    // 1.0 + 1.0 = 2.0
    send(8'h38, 1'b0); send(8'h38, 1'b1);
    get("p_1p1", 8'h40, 1'b0, 8'd2, 4); ack();
    // 1.5 + 1.5 = 3.0 via carry
    send(8'h3C, 1'b0); send(8'h3C, 1'b1);
    get("p_carry", 8'h44, 1'b0, 8'd2, 4); ack();
    // 1.5 - 1.0 = 0.5, one left shift
    send(8'h3C, 1'b0); send(8'hB8, 1'b1);
    get("p_cancel", 8'h30, 1'b0, 8'd2, 5); ack();
    // 1.0 - 1.0 = exact zero
    send(8'h38, 1'b0); send(8'hB8, 1'b1);
    get("p_zero", 8'h00, 1'b0, 8'd2, 4); ack();
    // 1.0 + 2^-4 truncates back to 1.0
    send(8'h38, 1'b0); send(8'h18, 1'b1);
    get("p_trunc", 8'h38, 1'b0, 8'd2, 4); ack();
    // single negative term
    send(8'hB0, 1'b1);
    get("p_single", 8'hB0, 1'b0, 8'd1, 4); ack();
    // negative zero input normalises to 0x00
    send(8'h80, 1'b1);
    get("p_negzero", 8'h00, 1'b0, 8'd1, 4); ack();
    // saturation, then hold with out_ready low
    send(8'h7F, 1'b0); send(8'h7F, 1'b1);
    get("p_sat", 8'h7F, 1'b1, 8'd2, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_data",     32'(bus.out_data),  32'h7F);
      chk("hold_sat",      32'(bus.out_sat),   32'd1);
      chk("hold_count",    32'(bus.out_count), 32'd2);
      chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
    end
    ack();
    // sat flag does not leak into the next packet
    send(8'h38, 1'b1);
    get("p_after_sat", 8'h38, 1'b0, 8'd1, 4); ack();

    // reset in the middle of a packet discards the accepted term
    send(8'h38, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data",  32'(bus.out_data),  32'd0);
    chk("mrst_out_sat",   32'(bus.out_sat),   32'd0);
    chk("mrst_out_count", 32'(bus.out_count), 32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b0;
    send(8'h40, 1'b1);
    get("p_post_rst", 8'h40, 1'b0, 8'd1, 4); ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
